// File: rtl/mux_pkg.sv
// Shared constants for the cache read-path selector.
package mux_pkg;
  localparam int DATA_W = 32;
  localparam logic SEL_FIRST = 1'b0;
  localparam logic SEL_SECOND = 1'b1;
endpackage

// File: rtl/mux_reg.sv
// Enable flop with asynchronous active-low clear.
module mux_reg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux.sv
// 2:1 cache-set data selector.
// Provides a combinational output and an optional registered copy.
module mux
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] second,
  input  logic             select,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q
);

  // Anything other than a clean 1 falls through to the first leg.
  always_comb begin
    out = first;
    if (select == SEL_SECOND) begin
      out = second;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      mux_reg #(
        .W(WIDTH + 1)
      ) u_reg (
        .clk(clk),
        .rst(rst),
        .en (en),
        .d  ({select, out}),
        .q  ({sel_q, out_q})
      );
    end else begin : g_noreg
      assign out_q = '0;
      assign sel_q = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mux.sv
// Directed and randomised checks for the mux selector.
module tb_mux;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  int errors = 0;
  int checks = 0;

  logic [31:0] f32 = '0, s32 = '0, o32, q32, qo;
  logic sel32 = 1'b0, sq32, so;
  logic [31:0] oo;

  logic f1 = 1'b0, s1 = 1'b0, sel1 = 1'b0, o1, q1, sq1;
  logic [63:0] f64 = '0, s64 = '0, o64, q64;
  logic sel64 = 1'b0, sq64;

  always #5 clk = ~clk;

  mux #(.WIDTH(32), .REG_OUT(1'b1)) u32 (
    .clk(clk), .rst(rst), .first(f32), .second(s32),
    .select(sel32), .en(en), .out(o32), .out_q(q32), .sel_q(sq32)
  );

  mux #(.WIDTH(32), .REG_OUT(1'b0)) uoff (
    .clk(clk), .rst(rst), .first(f32), .second(s32),
    .select(sel32), .en(en), .out(oo), .out_q(qo), .sel_q(so)
  );

  mux #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst(rst), .first(f1), .second(s1),
    .select(sel1), .en(en), .out(o1), .out_q(q1), .sel_q(sq1)
  );

  mux #(.WIDTH(64), .REG_OUT(1'b1)) u64 (
    .clk(clk), .rst(rst), .first(f64), .second(s64),
    .select(sel64), .en(en), .out(o64), .out_q(q64), .sel_q(sq64)
  );

  task automatic test_comb();
    f32 = 32'hAAAA_5555;
    s32 = 32'h1234_5678;
    sel32 = 1'b0;
    #1;
    checks++;
    if (o32 !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL comb_sel0: got %h want %h", o32, 32'hAAAA_5555);
    end
    sel32 = 1'b1;
    #0;
    checks++;
    if (o32 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL comb_sel1: got %h want %h", o32, 32'h1234_5678);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    sel32 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (q32 !== 32'h0) begin
        errors++;
        $display("FAIL rst_out_q: got %h want %h", q32, 32'h0);
      end
      checks++;
      if (sq32 !== 1'b0) begin
        errors++;
        $display("FAIL rst_sel_q: got %b want %b", sq32, 1'b0);
      end
      checks++;
      if (o32 !== 32'h1234_5678) begin
        errors++;
        $display("FAIL rst_out: got %h want %h", o32, 32'h1234_5678);
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] e_q;
    logic e_s;
    rst = 1'b1;
    en = 1'b1;
    sel32 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e_q = sel32 ? 32'h1234_5678 : 32'hAAAA_5555;
      e_s = sel32;
      @(negedge clk);
      checks++;
      if (q32 !== e_q) begin
        errors++;
        $display("FAIL lat_out_q[%0d]: got %h want %h", i, q32, e_q);
      end
      checks++;
      if (sq32 !== e_s) begin
        errors++;
        $display("FAIL lat_sel_q[%0d]: got %b want %b", i, sq32, e_s);
      end
      sel32 = ~sel32;
    end
  endtask

  task automatic test_hold();
    sel32 = 1'b1;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (q32 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL hold_load: got %h want %h", q32, 32'h1234_5678);
    end
    en = 1'b0;
    f32 = 32'h0;
    s32 = 32'hFFFF_0000;
    sel32 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (q32 !== 32'h1234_5678 || sq32 !== 1'b1) begin
        errors++;
        $display("FAIL hold_keep: got %h/%b want %h/%b",
                 q32, sq32, 32'h1234_5678, 1'b1);
      end
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (q32 !== 32'h0 || sq32 !== 1'b0) begin
      errors++;
      $display("FAIL hold_reload: got %h/%b want %h/%b",
               q32, sq32, 32'h0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    f32 = 32'hAAAA_5555;
    s32 = 32'h1234_5678;
    sel32 = 1'b0;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (q32 !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL async_pre: got %h want %h", q32, 32'hAAAA_5555);
    end
    sel32 = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (q32 !== 32'h0 || sq32 !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got %h/%b want %h/%b",
               q32, sq32, 32'h0, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (q32 !== 32'h0 || sq32 !== 1'b0) begin
      errors++;
      $display("FAIL async_wins: got %h/%b want %h/%b",
               q32, sq32, 32'h0, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (q32 !== 32'h1234_5678 || sq32 !== 1'b1) begin
      errors++;
      $display("FAIL async_release: got %h/%b want %h/%b",
               q32, sq32, 32'h1234_5678, 1'b1);
    end
  endtask

  task automatic test_reg_off();
    checks++;
    if (qo !== 32'h0 || so !== 1'b0) begin
      errors++;
      $display("FAIL regoff_q: got %h/%b want %h/%b", qo, so, 32'h0, 1'b0);
    end
    checks++;
    if (oo !== 32'h1234_5678) begin
      errors++;
      $display("FAIL regoff_out: got %h want %h", oo, 32'h1234_5678);
    end
  endtask

  task automatic test_random();
    logic [63:0] e64, eq64;
    logic e1, eq1, es64, es1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    eq64 = '0;
    es64 = 1'b0;
    eq1 = 1'b0;
    es1 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      f64 = {$urandom(), $urandom()};
      s64 = {$urandom(), $urandom()};
      sel64 = 1'($urandom_range(0, 1));
      f1 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      sel1 = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      e64 = sel64 ? s64 : f64;
      e1 = sel1 ? s1 : f1;
      #1;
      checks++;
      if (o64 !== e64 || o1 !== e1) begin
        errors++;
        $display("FAIL rnd_out[%0d]: got %h/%b want %h/%b",
                 i, o64, o1, e64, e1);
      end
      if (en) begin
        eq64 = e64;
        es64 = sel64;
        eq1 = e1;
        es1 = sel1;
      end
      @(negedge clk);
      checks++;
      if (q64 !== eq64 || sq64 !== es64) begin
        errors++;
        $display("FAIL rnd_q64[%0d]: got %h/%b want %h/%b",
                 i, q64, sq64, eq64, es64);
      end
      checks++;
      if (q1 !== eq1 || sq1 !== es1) begin
        errors++;
        $display("FAIL rnd_q1[%0d]: got %b/%b want %b/%b",
                 i, q1, sq1, eq1, es1);
      end
    end
  endtask

  initial begin
    test_comb();
    test_reset();
    test_latency();
    test_hold();
    test_async_reset();
    test_reg_off();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
